// File: rtl/pong_font_loader_pkg.sv
// Shared definitions for the score-digit font loader: FSM state codes, header tag and glyph layout.
// The glyph layout constants are also used by the score display.
package pong_font_loader_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_CHK   = 3'd3;
  localparam logic [2:0] S_PEND  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;

  localparam logic [3:0] HEADER_TAG_DEFAULT = 4'hF;

  localparam int unsigned GLYPH_ROWS      = 5;
  localparam int unsigned GLYPH_COLS      = 3;
  localparam int unsigned GLYPH_BLANK_BIT = 15;

  // Assemble a glyph word from its two bytes; the unused top bit is always stored as 0.
  function automatic logic [15:0] glyph_word(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] w;
    w = {hi, lo};
    w[GLYPH_BLANK_BIT] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/pong_byte_timeout.sv
// Reloadable inter-byte timeout: counts down while enabled, pulses o_Expired on the last allowed clock.
// Held at zero whenever disabled.
module pong_byte_timeout #(
  parameter int unsigned c_BYTE_TIMEOUT = 25000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Reload,
  input  logic i_Enable,
  output logic o_Expired
);

  localparam int unsigned CW = $clog2(c_BYTE_TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count <= '0;
    end else if (i_Reload) begin
      count <= CW'(c_BYTE_TIMEOUT - 1);
    end else if (!i_Enable) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A reload in the expiry cycle wins: the byte arrived just in time.
  assign o_Expired = i_Enable && !i_Reload && (count == CW'(1));

endmodule

// File: rtl/pong_font_loader.sv
// Writer side of the score-digit font RAM: parses HDR/HI/LO byte frames and defers the RAM write
// to vertical blanking. Define PONG_FONT_CHECKSUM_EN to require a trailing XOR checksum byte.
module pong_font_loader
  import pong_font_loader_pkg::*;
#(
  parameter int unsigned c_ADDR_WIDTH   = 4,
  parameter int unsigned c_DATA_WIDTH   = 16,
  parameter logic [3:0]  c_HEADER_TAG   = HEADER_TAG_DEFAULT,
  parameter int unsigned c_BYTE_TIMEOUT = 25000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_Rx_DV,
  input  logic [7:0]              i_Rx_Byte,
  input  logic                    i_Blank,
  output logic                    o_Wr_En,
  output logic [c_ADDR_WIDTH-1:0] o_Wr_Addr,
  output logic [c_DATA_WIDTH-1:0] o_Wr_Data,
  output logic                    o_Busy,
  output logic                    o_Err
);

  logic [2:0]              state;
  logic [c_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]              hi_q;
  logic [c_DATA_WIDTH-1:0] glyph_q;
  logic                    hdr_ok;
  logic                    reload;
  logic                    enable;
  logic                    expired;
`ifdef PONG_FONT_CHECKSUM_EN
  logic [7:0]              sum_q;
`endif

  assign hdr_ok = (i_Rx_Byte[7:4] == c_HEADER_TAG);
  assign enable = (state == S_HI) || (state == S_LO) || (state == S_CHK);
  assign o_Busy = (state != S_IDLE);

  // Reload only on bytes that leave the FSM in a byte-waiting state, so the counter stays idle otherwise.
  always_comb begin
    reload = 1'b0;
    case (state)
      S_IDLE:  reload = i_Rx_DV && hdr_ok;
      S_HI:    reload = i_Rx_DV;
`ifdef PONG_FONT_CHECKSUM_EN
      S_LO:    reload = i_Rx_DV;
`endif
      default: reload = 1'b0;
    endcase
  end

  pong_byte_timeout #(
    .c_BYTE_TIMEOUT(c_BYTE_TIMEOUT)
  ) u_timeout (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_Reload  (reload),
    .i_Enable  (enable),
    .o_Expired (expired)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      hi_q      <= '0;
      glyph_q   <= '0;
      o_Wr_En   <= 1'b0;
      o_Wr_Addr <= '0;
      o_Wr_Data <= '0;
      o_Err     <= 1'b0;
`ifdef PONG_FONT_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      o_Wr_En <= 1'b0;
      o_Err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_Rx_DV && hdr_ok) begin
            addr_q <= i_Rx_Byte[c_ADDR_WIDTH-1:0];
            state  <= S_HI;
`ifdef PONG_FONT_CHECKSUM_EN
            sum_q  <= i_Rx_Byte;
`endif
          end
        end
        S_HI: begin
          if (i_Rx_DV) begin
            hi_q  <= i_Rx_Byte;
            state <= S_LO;
`ifdef PONG_FONT_CHECKSUM_EN
            sum_q <= sum_q ^ i_Rx_Byte;
`endif
          end else if (expired) begin
            state <= S_IDLE;
            o_Err <= 1'b1;
          end
        end
        S_LO: begin
          if (i_Rx_DV) begin
            glyph_q <= c_DATA_WIDTH'(glyph_word(hi_q, i_Rx_Byte));
`ifdef PONG_FONT_CHECKSUM_EN
            sum_q   <= sum_q ^ i_Rx_Byte;
            state   <= S_CHK;
`else
            state   <= S_PEND;
`endif
          end else if (expired) begin
            state <= S_IDLE;
            o_Err <= 1'b1;
          end
        end
`ifdef PONG_FONT_CHECKSUM_EN
        S_CHK: begin
          if (i_Rx_DV) begin
            if (i_Rx_Byte == sum_q) begin
              state <= S_PEND;
            end else begin
              state <= S_IDLE;
              o_Err <= 1'b1;
            end
          end else if (expired) begin
            state <= S_IDLE;
            o_Err <= 1'b1;
          end
        end
`endif
        S_PEND: begin
          if (i_Rx_DV) o_Err <= 1'b1;
          if (i_Blank) begin
            state     <= S_WRITE;
            o_Wr_En   <= 1'b1;
            o_Wr_Addr <= addr_q;
            o_Wr_Data <= glyph_q;
          end
        end
        S_WRITE: begin
          if (i_Rx_DV) o_Err <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_font_loader.sv
// Self-checking bench for pong_font_loader: directed frames plus random byte streams, compared
// every clock against a byte-queue reference model. Honours PONG_FONT_CHECKSUM_EN.
module tb_pong_font_loader;

  localparam int unsigned T = 12;
`ifdef PONG_FONT_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        blank = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  pong_font_loader #(
    .c_ADDR_WIDTH   (4),
    .c_DATA_WIDTH   (16),
    .c_HEADER_TAG   (4'hF),
    .c_BYTE_TIMEOUT (T)
  ) dut (
    .i_Clk     (clk),
    .i_Rst_n   (rst_n),
    .i_Rx_DV   (rx_dv),
    .i_Rx_Byte (rx_byte),
    .i_Blank   (blank),
    .o_Wr_En   (wr_en),
    .o_Wr_Addr (wr_addr),
    .o_Wr_Data (wr_data),
    .o_Busy    (busy),
    .o_Err     (err)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the frame in progress, a pending glyph, and a one-cycle write phase.
  logic [7:0]  frame[$];
  bit          m_pend, m_writing;
  logic [3:0]  m_paddr;
  logic [15:0] m_pdata;
  int          gap;
  bit          exp_wr_en, exp_err;
  logic [3:0]  exp_addr;
  logic [15:0] exp_data;
  bit          blank_st = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("wr_en",   32'(wr_en),   32'(exp_wr_en));
    check_eq("err",     32'(err),     32'(exp_err));
    check_eq("busy",    32'(busy),    32'(m_writing || m_pend || frame.size() != 0));
    check_eq("wr_addr", 32'(wr_addr), 32'(exp_addr));
    check_eq("wr_data", 32'(wr_data), 32'(exp_data));
  endtask

  task automatic model_reset();
    frame.delete();
    m_pend = 0; m_writing = 0; gap = 0;
    exp_wr_en = 0; exp_err = 0; exp_addr = '0; exp_data = '0;
  endtask

  task automatic model_step(input bit dv, input logic [7:0] b, input bit blk);
    logic [7:0] h, d1, d2;
    bit ok;
    exp_wr_en = 0;
    exp_err   = 0;
    if (m_writing) begin
      m_writing = 0;
      if (dv) exp_err = 1;
    end else if (m_pend) begin
      if (dv) exp_err = 1;
      if (blk) begin
        m_pend = 0; m_writing = 1; exp_wr_en = 1;
        exp_addr = m_paddr; exp_data = m_pdata;
      end
    end else if (frame.size() == 0) begin
      if (dv && b[7:4] == 4'hF) begin
        frame.push_back(b);
        gap = 0;
      end
    end else if (dv) begin
      frame.push_back(b);
      gap = 0;
      if (frame.size() == FRAME_LEN) begin
        h = frame[0]; d1 = frame[1]; d2 = frame[2];
        ok = 1;
`ifdef PONG_FONT_CHECKSUM_EN
        ok = ((h ^ d1 ^ d2) == frame[3]);
`endif
        if (ok) begin
          m_pend  = 1;
          m_paddr = h[3:0];
          m_pdata = {1'b0, d1[6:0], d2};
        end else begin
          exp_err = 1;
        end
        frame.delete();
      end
    end else begin
      gap++;
      if (gap == int'(T) - 1) begin
        exp_err = 1;
        frame.delete();
      end
    end
  endtask

  task automatic cycle(input bit dv, input logic [7:0] b, input bit blk);
    @(negedge clk);
    rx_dv = dv; rx_byte = b; blank = blk;
    @(posedge clk);
    model_step(dv, b, blk);
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b, input bit blk);
    cycle(1'b1, b, blk);
  endtask

  task automatic idle(input int n, input bit blk);
    repeat (n) cycle(1'b0, 8'($urandom), blk);
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [7:0] hi, input logic [7:0] lo,
                            input bit blk, input logic [7:0] chk_flip);
    send({4'hF, a}, blk);
    send(hi, blk);
    send(lo, blk);
`ifdef PONG_FONT_CHECKSUM_EN
    send({4'hF, a} ^ hi ^ lo ^ chk_flip, blk);
`else
    if (chk_flip != 8'h00) idle(0, blk);
`endif
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rx_dv = 1'b0; blank = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_step(rx_dv, rx_byte, blank);
    #1;
    check_outputs();
  endtask

  function automatic bit next_blank();
    if ($urandom_range(0, 4) == 0) blank_st = !blank_st;
    return blank_st;
  endfunction

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 8) return int'($urandom_range(1, 4));
    if (r == 8) return int'(T) - 2;
    return int'(T) - 1;
  endfunction

  task automatic idle_rand(input int n);
    repeat (n) cycle(1'b0, 8'($urandom), next_blank());
  endtask

  initial begin
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    blank = 1'b1;
    @(posedge clk);
    model_step(1'b0, 8'h00, 1'b1);
    #1;
    check_outputs();

    send_frame(4'h3, 8'h12, 8'h34, 1'b1, 8'h00);
    idle(3, 1'b1);
    send_frame(4'h7, 8'hFF, 8'hFF, 1'b1, 8'h00);
    send(8'h42, 1'b1);
    idle(3, 1'b1);
    send_frame(4'h1, 8'h00, 8'h07, 1'b0, 8'h00);
    idle(4, 1'b0);
    idle(4, 1'b1);

    send(8'hF2, 1'b1);
    send(8'hAA, 1'b1);
    idle(int'(T) + 1, 1'b1);
    send(8'hF2, 1'b1);
    send(8'hAA, 1'b1);
    idle(int'(T) - 2, 1'b1);
    send(8'h55, 1'b1);
`ifdef PONG_FONT_CHECKSUM_EN
    send(8'hF2 ^ 8'hAA ^ 8'h55, 1'b1);
`endif
    idle(3, 1'b1);

    send_frame(4'h6, 8'h5A, 8'hA5, 1'b0, 8'h00);
    idle(1, 1'b0);
    send(8'h55, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    send(8'hF5, 1'b1);
    send(8'h11, 1'b1);
    pulse_reset();
    idle(4, 1'b1);

`ifdef PONG_FONT_CHECKSUM_EN
    send(8'hF4, 1'b1); send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'hF7, 1'b1);
    idle(3, 1'b1);
    send(8'hF4, 1'b1); send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h00, 1'b1);
    idle(3, 1'b1);
`endif

    for (int f = 0; f < 250; f++) begin
      logic [7:0] bytes[4];
      int kind;
      int nb;
      kind = int'($urandom_range(0, 15));
      bytes[0] = (kind == 0) ? 8'($urandom_range(0, 239)) : {4'hF, 4'($urandom)};
      bytes[1] = 8'($urandom);
      bytes[2] = 8'($urandom);
      bytes[3] = bytes[0] ^ bytes[1] ^ bytes[2];
      if (kind == 1) bytes[3] = bytes[3] ^ (8'h01 << $urandom_range(0, 7));
      nb = (kind == 2) ? 2 : FRAME_LEN;
      for (int i = 0; i < nb; i++) begin
        idle_rand(pick_gap());
        send(bytes[i], next_blank());
      end
      if (kind == 2) idle_rand(int'(T) + 1);
      if (kind == 3) pulse_reset();
    end
    idle(int'(T) + 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
